// File: rtl/rv_pkg.sv
// Shared RV32I-Trap pipeline definitions.
// Holds fetch-side constants and the fetch FSM state type.
package rv_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    WAIT_TRAP
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Flush beats a misaligned load, which beats a normal enabled load.
module if_id_reg
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] NOP = NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic        load_misaligned,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o,
  output logic        misaligned_o
);

  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        valid_q;
  logic        mis_q;

  // A flushed entry keeps its old pc; only valid entries carry a meaningful pc.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      inst_q  <= NOP;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else if (flush) begin
      inst_q  <= NOP;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else if (load_misaligned) begin
      pc_q    <= pc_i;
      inst_q  <= NOP;
      valid_q <= 1'b1;
      mis_q   <= 1'b1;
    end else if (en) begin
      pc_q    <= pc_i;
      inst_q  <= inst_i;
      valid_q <= 1'b1;
      mis_q   <= 1'b0;
    end
  end

  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign valid_o      = valid_q;
  assign misaligned_o = mis_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, redirect mux, fetch FSM.
// Drives a sync-read imem and feeds the IF/ID register.
module fetch_stage
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] NOP = NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_en,
  input  logic        IF_ID_en,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        trap_taken,
  input  logic [31:0] trap_vector,
  input  logic        mret,
  input  logic [31:0] mepc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_inst,
  output logic        IF_ID_valid,
  output logic        IF_ID_misaligned,
  output logic [4:0]  IF_ID_rs1,
  output logic [4:0]  IF_ID_rs2
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redir_addr;
  logic         redir;
  logic         pc_mis;
  logic         flush;
  logic         load_mis;

  assign redir  = trap_taken | mret | branch_taken;
  assign pc_mis = pc_q[1:0] != 2'b00;

  always_comb begin
    redir_addr = branch_target;
    priority case (1'b1)
      trap_taken: redir_addr = trap_vector;
      mret:       redir_addr = mepc;
      default:    redir_addr = branch_target;
    endcase
  end

  // BOOT holds the PC so the reset-vector word is re-read for RUN.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    flush    = redir;
    load_mis = 1'b0;
    unique case (state_q)
      BOOT: begin
        flush   = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (!redir && pc_mis && IF_ID_en) begin
          load_mis = 1'b1;
          state_d  = WAIT_TRAP;
        end else if (pc_en) begin
          pc_d = pc_q + 32'd4;
        end
      end
      WAIT_TRAP: begin
        if (IF_ID_en) flush = 1'b1;
      end
      default: state_d = BOOT;
    endcase
    if (redir) begin
      pc_d    = redir_addr;
      state_d = RUN;
    end
  end

  assign imem_addr = rst ? RESET_VECTOR : pc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      state_q <= BOOT;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  if_id_reg #(
    .RESET_VECTOR(RESET_VECTOR),
    .NOP         (NOP)
  ) u_if_id (
    .clk            (clk),
    .rst            (rst),
    .en             (IF_ID_en),
    .flush          (flush),
    .load_misaligned(load_mis),
    .pc_i           (pc_q),
    .inst_i         (imem_rdata),
    .pc_o           (IF_ID_pc),
    .inst_o         (IF_ID_inst),
    .valid_o        (IF_ID_valid),
    .misaligned_o   (IF_ID_misaligned)
  );

  assign IF_ID_rs1 = IF_ID_inst[19:15];
  assign IF_ID_rs2 = IF_ID_inst[24:20];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, then random
// stimulus against a cycle-level behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] NOPI = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_en;
  logic        IF_ID_en;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        trap_taken;
  logic [31:0] trap_vector;
  logic        mret;
  logic [31:0] mepc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_inst;
  logic        IF_ID_valid;
  logic        IF_ID_misaligned;
  logic [4:0]  IF_ID_rs1;
  logic [4:0]  IF_ID_rs2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .pc_en           (pc_en),
    .IF_ID_en        (IF_ID_en),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .trap_taken      (trap_taken),
    .trap_vector     (trap_vector),
    .mret            (mret),
    .mepc            (mepc),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .IF_ID_pc        (IF_ID_pc),
    .IF_ID_inst      (IF_ID_inst),
    .IF_ID_valid     (IF_ID_valid),
    .IF_ID_misaligned(IF_ID_misaligned),
    .IF_ID_rs1       (IF_ID_rs1),
    .IF_ID_rs2       (IF_ID_rs2)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hDEAD_5000;
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) imem_rdata <= memf(imem_addr);

  typedef struct {
    logic        rst, pe, ie;
    logic        br;
    logic [31:0] bt;
    logic        tr;
    logic [31:0] tv;
    logic        mr;
    logic [31:0] mp;
    logic [31:0] ea;
    logic        ev, em, cp;
    logic [31:0] epc;
  } vec_t;

  vec_t vq[$];

  task automatic add(
    input logic rs, pe, ie,
    input logic br, input logic [31:0] bt,
    input logic tr, input logic [31:0] tv,
    input logic mr, input logic [31:0] mp,
    input logic [31:0] ea,
    input logic ev, em, cp, input logic [31:0] epc
  );
    vec_t v;
    v.rst = rs; v.pe = pe; v.ie = ie;
    v.br = br; v.bt = bt;
    v.tr = tr; v.tv = tv;
    v.mr = mr; v.mp = mp;
    v.ea = ea;
    v.ev = ev; v.em = em; v.cp = cp; v.epc = epc;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    logic [31:0] ei;
    rst = v.rst; pc_en = v.pe; IF_ID_en = v.ie;
    branch_taken = v.br; branch_target = v.bt;
    trap_taken = v.tr; trap_vector = v.tv;
    mret = v.mr; mepc = v.mp;
    #2;
    chk("imem_addr", imem_addr, v.ea);
    @(posedge clk);
    #1;
    ei = (v.ev && !v.em) ? memf(v.epc) : NOPI;
    chk("valid", {31'd0, IF_ID_valid}, {31'd0, v.ev});
    chk("misaligned", {31'd0, IF_ID_misaligned}, {31'd0, v.em});
    chk("inst", IF_ID_inst, ei);
    chk("rs1", {27'd0, IF_ID_rs1}, {27'd0, ei[19:15]});
    chk("rs2", {27'd0, IF_ID_rs2}, {27'd0, ei[24:20]});
    if (v.cp) chk("IF_ID_pc", IF_ID_pc, v.epc);
  endtask

  // Behavioural model: what fetch should do, cycle by cycle.
  logic [31:0] m_pc, o_pc;
  bit          m_boot, m_halt, o_v, o_m;

  task automatic model(inout vec_t v);
    logic [31:0] ra;
    if (v.rst) begin
      m_pc = 0; m_boot = 1; m_halt = 0;
      o_v = 0; o_m = 0; o_pc = 0;
      v.ea = 0;
    end else if (v.tr || v.mr || v.br) begin
      ra = v.tr ? v.tv : (v.mr ? v.mp : v.bt);
      v.ea = ra; m_pc = ra;
      m_boot = 0; m_halt = 0;
      o_v = 0; o_m = 0;
    end else if (m_boot) begin
      v.ea = m_pc; o_v = 0; o_m = 0; m_boot = 0;
    end else if (m_halt) begin
      v.ea = m_pc;
      if (v.ie) begin o_v = 0; o_m = 0; end
    end else if ((m_pc % 4) != 0 && v.ie) begin
      v.ea = m_pc; o_v = 1; o_m = 1; o_pc = m_pc; m_halt = 1;
    end else begin
      v.ea = v.pe ? m_pc + 4 : m_pc;
      if (v.ie) begin o_v = 1; o_m = 0; o_pc = m_pc; end
      m_pc = v.ea;
    end
    v.ev = o_v; v.em = o_m; v.epc = o_pc;
    v.cp = o_v || v.rst;
  endtask

  function automatic logic [31:0] rtarget();
    logic [31:0] t;
    t = $urandom & 32'h0000_FFFC;
    if ($urandom_range(0, 7) == 0) t = t | 32'($urandom_range(1, 3));
    return t;
  endfunction

  initial begin
    vec_t v;
    // reset, boot bubble, straight-line fetch
    add(1,1,1, 0,0, 0,0, 0,0, 32'h0,   0,0,1,32'h0);
    add(0,1,1, 0,0, 0,0, 0,0, 32'h0,   0,0,0,32'h0);
    add(0,1,1, 0,0, 0,0, 0,0, 32'h4,   1,0,1,32'h0);
    add(0,1,1, 0,0, 0,0, 0,0, 32'h8,   1,0,1,32'h4);
    add(0,1,1, 0,0, 0,0, 0,0, 32'hC,   1,0,1,32'h8);
    add(0,1,1, 0,0, 0,0, 0,0, 32'h10,  1,0,1,32'hC);
    // three-cycle stall at pc 0x10
    for (int i = 0; i < 3; i++)
      add(0,0,0, 0,0, 0,0, 0,0, 32'h10, 1,0,1,32'hC);
    add(0,1,1, 0,0, 0,0, 0,0, 32'h14,  1,0,1,32'h10);
    add(0,1,1, 0,0, 0,0, 0,0, 32'h18,  1,0,1,32'h14);
    // branch overriding a stall
    add(0,0,0, 1,32'h100, 0,0, 0,0, 32'h100, 0,0,0,0);
    add(0,1,1, 0,0, 0,0, 0,0, 32'h104, 1,0,1,32'h100);
    // trap beats branch, mret beats branch
    add(0,1,1, 1,32'h100, 1,32'h200, 0,0, 32'h200, 0,0,0,0);
    add(0,1,1, 0,0, 0,0, 0,0, 32'h204, 1,0,1,32'h200);
    add(0,1,1, 1,32'h100, 0,0, 1,32'h300, 32'h300, 0,0,0,0);
    add(0,1,1, 0,0, 0,0, 0,0, 32'h304, 1,0,1,32'h300);
    // misaligned target, wait for trap
    add(0,1,1, 1,32'h102, 0,0, 0,0, 32'h102, 0,0,0,0);
    add(0,1,1, 0,0, 0,0, 0,0, 32'h102, 1,1,1,32'h102);
    add(0,1,1, 0,0, 0,0, 0,0, 32'h102, 0,0,0,0);
    add(0,1,1, 0,0, 0,0, 0,0, 32'h102, 0,0,0,0);
    add(0,1,1, 0,0, 1,32'h400, 0,0, 32'h400, 0,0,0,0);
    add(0,1,1, 0,0, 0,0, 0,0, 32'h404, 1,0,1,32'h400);
    // reset while waiting for trap, then redirect during boot
    add(0,1,1, 1,32'h106, 0,0, 0,0, 32'h106, 0,0,0,0);
    add(0,1,1, 0,0, 0,0, 0,0, 32'h106, 1,1,1,32'h106);
    add(0,1,1, 0,0, 0,0, 0,0, 32'h106, 0,0,0,0);
    add(1,1,1, 1,32'h700, 0,0, 0,0, 32'h0, 0,0,1,32'h0);
    add(0,1,1, 1,32'h500, 0,0, 0,0, 32'h500, 0,0,0,0);
    add(0,1,1, 0,0, 0,0, 0,0, 32'h504, 1,0,1,32'h500);
    // PC wrap-around
    add(0,1,1, 1,32'hFFFF_FFFC, 0,0, 0,0, 32'hFFFF_FFFC, 0,0,0,0);
    add(0,1,1, 0,0, 0,0, 0,0, 32'h0,   1,0,1,32'hFFFF_FFFC);
    add(0,1,1, 0,0, 0,0, 0,0, 32'h4,   1,0,1,32'h0);
    // branch out of the trap wait, IF/ID stalled while waiting
    add(0,1,1, 1,32'h2, 0,0, 0,0, 32'h2, 0,0,0,0);
    add(0,1,1, 0,0, 0,0, 0,0, 32'h2,   1,1,1,32'h2);
    add(0,1,0, 0,0, 0,0, 0,0, 32'h2,   1,1,1,32'h2);
    add(0,1,1, 1,32'h40, 0,0, 0,0, 32'h40, 0,0,0,0);
    add(0,1,1, 0,0, 0,0, 0,0, 32'h44,  1,0,1,32'h40);

    foreach (vq[i]) apply(vq[i]);

    // randomized phase against the model
    m_pc = 0; o_pc = 0; m_boot = 1; m_halt = 0; o_v = 0; o_m = 0;
    for (int n = 0; n < 600; n++) begin
      v.rst = (n == 0) || ($urandom_range(0, 79) == 0);
      v.pe  = $urandom_range(0, 5) != 0;
      v.ie  = (v.pe && $urandom_range(0, 7) != 0) ||
              $urandom_range(0, 3) == 0;
      v.br  = $urandom_range(0, 9) == 0;
      v.bt  = rtarget();
      v.tr  = $urandom_range(0, 19) == 0;
      v.tv  = rtarget() & 32'hFFFF_FFFC;
      v.mr  = $urandom_range(0, 24) == 0;
      v.mp  = rtarget();
      model(v);
      apply(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
